// File: rtl/blink_pkg.sv
// ----------------------------------------------------------------------------
// Package : blink_pkg
// Brief   : Shared types for the pattern_blinker channel generator
//           (configuration modes and per-channel FSM states).
// Rev     : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package blink_pkg;

  typedef enum logic [1:0] {
    MODE_STOP    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_REPEAT  = 2'd2,
    MODE_SQUARE  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pattern_blinker_if.sv
// ----------------------------------------------------------------------------
// Interface : pattern_blinker_if
// Brief     : valid/ready configuration port of pattern_blinker. The master
//             drives a config word, the slave (the blinker) returns ready.
// Rev       : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface pattern_blinker_if #(
  parameter int NUM_CH    = 4,
  parameter int PATTERN_W = 32,
  parameter int DIV_W     = 26
) ();
  import blink_pkg::*;

  localparam int CH_W  = $clog2(NUM_CH) + 1;
  localparam int LEN_W = $clog2(PATTERN_W) + 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  mode_e                cfg_mode;
  logic [DIV_W-1:0]     cfg_div;
  logic [LEN_W-1:0]     cfg_len;
  logic [PATTERN_W-1:0] cfg_pat;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_div, cfg_len, cfg_pat,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_div, cfg_len, cfg_pat,
    output cfg_ready
  );

endinterface

`default_nettype wire

// File: rtl/blink_channel.sv
// ----------------------------------------------------------------------------
// Module : blink_channel
// Brief  : One output channel: bit-period divider, pattern index and
//          IDLE/RUN/DONE state machine. Shifts the loaded pattern out LSB
//          first, one bit every div+1 clocks, one-shot or repeating.
//          Optional: BLINK_SQUARE_EN builds the SQUARE toggle mode.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module blink_channel
  import blink_pkg::*;
#(
  parameter int PATTERN_W = 32,
  parameter int DIV_W     = 26,
  parameter int LEN_W     = $clog2(PATTERN_W) + 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 enable,
  input  wire logic                 load,
  input  wire mode_e                load_mode,
  input  wire logic [DIV_W-1:0]     load_div,
  input  wire logic [LEN_W-1:0]     load_len,
  input  wire logic [PATTERN_W-1:0] load_pat,
  output logic                      out,
  output logic                      done
);

  localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PATTERN_W);

  state_e               state, state_next;
  mode_e                mode;
  logic [DIV_W-1:0]     div, pc, pc_next;
  logic [LEN_W-1:0]     len, len_clamped;
  logic [PATTERN_W-1:0] pat;
  logic [IDX_W-1:0]     idx, idx_next;
  logic                 out_next;
  logic                 start_run;
  logic                 is_square;
  logic                 last_bit;

  assign len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  assign last_bit    = (LEN_W'(idx) == (len - LEN_W'(1)));

`ifdef BLINK_SQUARE_EN
  assign is_square = (mode == MODE_SQUARE);
`else
  assign is_square = 1'b0;
`endif

  // Decide whether a freshly loaded word starts the channel running
  always_comb begin
    start_run = 1'b0;
    case (load_mode)
      MODE_ONESHOT, MODE_REPEAT: start_run = (load_len != '0);
`ifdef BLINK_SQUARE_EN
      MODE_SQUARE:               start_run = 1'b1;
`endif
      default:                   start_run = 1'b0;
    endcase
  end

  // Next state, divider/index advance, next output bit and done pulse
  always_comb begin
    state_next = state;
    pc_next    = pc;
    idx_next   = idx;
    out_next   = out;
    done       = 1'b0;
    if (load) begin
      // A reload always restarts the channel from bit 0, discarding history
      pc_next    = '0;
      idx_next   = '0;
      state_next = start_run ? ST_RUN : ST_IDLE;
      out_next   = (start_run && (load_mode != MODE_SQUARE)) ? load_pat[0] : 1'b0;
    end else if (!rst && enable && (state == ST_RUN)) begin
      pc_next = pc + DIV_W'(1);
      if (pc == div) begin
        pc_next = '0;
        if (is_square) begin
          out_next = ~out;
        end else if (last_bit) begin
          if (mode == MODE_REPEAT) begin
            idx_next = '0;
            out_next = pat[0];
          end else begin
            state_next = ST_DONE;
            out_next   = 1'b0;
            done       = 1'b1;
          end
        end else begin
          idx_next = idx + IDX_W'(1);
          out_next = pat[idx_next];
        end
      end
    end
  end

  // Channel state and configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      mode  <= MODE_STOP;
      div   <= '0;
      len   <= '0;
      pat   <= '0;
      pc    <= '0;
      idx   <= '0;
      out   <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      idx   <= idx_next;
      out   <= out_next;
      if (load) begin
        mode <= load_mode;
        div  <= load_div;
        len  <= len_clamped;
        pat  <= load_pat;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pattern_blinker.sv
// ----------------------------------------------------------------------------
// Module : pattern_blinker
// Brief  : Multi-channel run-time programmable pattern/strobe generator.
//          Accepts one config word per cycle, decodes the channel index into
//          per-channel load strobes and flags out-of-range indices.
//          Optional: BLINK_SQUARE_EN enables the SQUARE toggle mode.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pattern_blinker
  import blink_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PATTERN_W = 32,
  parameter int DIV_W     = 26
) (
  input  wire logic        CLK,
  input  wire logic        RST,
  input  wire logic        enable,
  pattern_blinker_if.slave cfg,
  output logic [NUM_CH-1:0] chan_out,
  output logic [NUM_CH-1:0] done,
  output logic              cfg_err
);

  localparam int CH_W  = $clog2(NUM_CH) + 1;
  localparam int LEN_W = $clog2(PATTERN_W) + 1;

  logic ready;
  logic rst_q;
  logic accept;

  assign accept        = cfg.cfg_valid & ready;
  assign cfg.cfg_ready = ready;

  // Ready stays low through reset and the cycle after; error flag is a
  // one-cycle pulse following an accepted out-of-range channel index
  always_ff @(posedge CLK) begin
    if (RST) begin
      rst_q   <= 1'b1;
      ready   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      rst_q   <= 1'b0;
      ready   <= ~rst_q;
      cfg_err <= accept && (cfg.cfg_ch >= CH_W'(NUM_CH));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load;
    assign load = accept && (cfg.cfg_ch == CH_W'(i));

    blink_channel #(
      .PATTERN_W (PATTERN_W),
      .DIV_W     (DIV_W),
      .LEN_W     (LEN_W)
    ) u_channel (
      .clk       (CLK),
      .rst       (RST),
      .enable    (enable),
      .load      (load),
      .load_mode (cfg.cfg_mode),
      .load_div  (cfg.cfg_div),
      .load_len  (cfg.cfg_len),
      .load_pat  (cfg.cfg_pat),
      .out       (chan_out[i]),
      .done      (done[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pattern_blinker.sv
// ----------------------------------------------------------------------------
// Module : tb_pattern_blinker
// Brief  : Self-checking bench for pattern_blinker: table of config words with
//          expected per-cycle output/done sequences fed through a scoreboard
//          queue, plus hand-written reset, enable, error and reload sequences.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pattern_blinker;
  import blink_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int PATTERN_W = 32;
  localparam int DIV_W     = 26;
  localparam int CH_W      = $clog2(NUM_CH) + 1;
  localparam int LEN_W     = $clog2(PATTERN_W) + 1;
  localparam int NV        = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [NUM_CH-1:0] chan_out;
  logic [NUM_CH-1:0] done;
  logic              cfg_err;

  pattern_blinker_if #(.NUM_CH(NUM_CH), .PATTERN_W(PATTERN_W), .DIV_W(DIV_W)) bus ();

  pattern_blinker #(.NUM_CH(NUM_CH), .PATTERN_W(PATTERN_W), .DIV_W(DIV_W)) dut (
    .CLK      (clk),
    .RST      (rst),
    .enable   (enable),
    .cfg      (bus),
    .chan_out (chan_out),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    mode_e       mode;
    int          div;
    int          len;
    logic [31:0] pat;
    int          ncy;
    logic [63:0] eo;
    logic [63:0] ed;
  } vec_t;

  typedef struct {
    int   ch;
    logic eo;
    logic ed;
  } exp_t;

  vec_t vt[NV];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(int ch, mode_e m, int div, int len, logic [31:0] pat,
                              int ncy, logic [63:0] eo, logic [63:0] ed);
    vec_t v;
    v.ch = ch; v.mode = m; v.div = div; v.len = len; v.pat = pat;
    v.ncy = ncy; v.eo = eo; v.ed = ed;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push_exp(int ch, logic eo, logic ed);
    exp_t e;
    e.ch = ch; e.eo = eo; e.ed = ed;
    sb.push_back(e);
  endtask

  // Pops one expectation and compares {chan_out[ch], done[ch]} against it
  task automatic pop_check(string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: scoreboard empty, got out/done, required an expectation", nm);
    end else begin
      e = sb.pop_front();
      check(nm, {30'd0, chan_out[e.ch], done[e.ch]}, {30'd0, e.eo, e.ed});
    end
  endtask

  task automatic expect_now(int ch, logic eo, logic ed, string nm);
    push_exp(ch, eo, ed);
    pop_check(nm);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send(int ch, mode_e m, int div, int len, logic [31:0] pat);
    int w = 0;
    while (bus.cfg_ready !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (bus.cfg_ready !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout: got cfg_ready=%b, required 1", bus.cfg_ready);
    end
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = CH_W'(ch);
    bus.cfg_mode  = m;
    bus.cfg_div   = DIV_W'(div);
    bus.cfg_len   = LEN_W'(len);
    bus.cfg_pat   = pat;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [8:0] resume_seq;

    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_mode  = MODE_STOP;
    bus.cfg_div   = '0;
    bus.cfg_len   = '0;
    bus.cfg_pat   = '0;

    vt[0] = mk(0, MODE_REPEAT,  2, 4,  32'hB,          14, 64'h3E3F,      64'h0);
    vt[1] = mk(1, MODE_ONESHOT, 0, 3,  32'h5,           6, 64'h5,         64'h4);
    vt[2] = mk(1, MODE_ONESHOT, 0, 3,  32'h5,           6, 64'h5,         64'h4);
    vt[3] = mk(2, MODE_ONESHOT, 0, 40, 32'h8000_0001,  36, 64'h8000_0001, 64'h8000_0000);
    vt[4] = mk(3, MODE_ONESHOT, 1, 2,  32'h2,           6, 64'hC,         64'h8);
    vt[5] = mk(0, MODE_STOP,    0, 4,  32'hF,           4, 64'h0,         64'h0);
    vt[6] = mk(1, MODE_REPEAT,  1, 1,  32'h1,           5, 64'h1F,        64'h0);
    vt[7] = mk(2, MODE_ONESHOT, 0, 0,  32'hFF,          3, 64'h0,         64'h0);
`ifdef BLINK_SQUARE_EN
    vt[8] = mk(3, MODE_SQUARE,  1, 1,  32'hFFFF_FFFF,   8, 64'hCC,        64'h0);
`else
    vt[8] = mk(3, MODE_SQUARE,  1, 1,  32'hFFFF_FFFF,   8, 64'h0,         64'h0);
`endif

    // Reset: three cycles high, ready low until the second cycle after release
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_chan_out", 32'(chan_out), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_ready", 32'(bus.cfg_ready), 32'h0);
    end
    check("rst_cfg_err", 32'(cfg_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst1", 32'(bus.cfg_ready), 32'h0);
    @(negedge clk);
    check("ready_after_rst2", 32'(bus.cfg_ready), 32'h1);
    enable = 1'b1;

    // Table-driven vectors through the scoreboard
    for (int v = 0; v < NV; v++) begin
      send(vt[v].ch, vt[v].mode, vt[v].div, vt[v].len, vt[v].pat);
      for (int k = 0; k < vt[v].ncy; k++) push_exp(vt[v].ch, vt[v].eo[k], vt[v].ed[k]);
      while (sb.size() > 0) begin
        pop_check($sformatf("vec%0d", v));
        if (sb.size() > 0) @(negedge clk);
      end
    end

    // Enable low for 5 cycles mid-bit: output and phase frozen
    send(0, MODE_REPEAT, 4, 2, 32'h1);
    expect_now(0, 1'b1, 1'b0, "en_run");
    @(negedge clk);
    expect_now(0, 1'b1, 1'b0, "en_run");
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_now(0, 1'b1, 1'b0, "en_hold");
    end
    enable = 1'b1;
    resume_seq = 9'h107;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      expect_now(0, resume_seq[k], 1'b0, "en_resume");
    end

    // Out-of-range channel index: error pulse, no channel changes
    for (int c = 0; c < NUM_CH; c++) send(c, MODE_REPEAT, 0, 1, 32'h1);
    check("all_on", 32'(chan_out), 32'hF);
    check("no_err_good", 32'(cfg_err), 32'h0);
    send(NUM_CH, MODE_STOP, 0, 0, 32'h0);
    check("err_pulse", 32'(cfg_err), 32'h1);
    check("err_no_change", 32'(chan_out), 32'hF);
    @(negedge clk);
    check("err_clear", 32'(cfg_err), 32'h0);
    check("err_no_change2", 32'(chan_out), 32'hF);
    send(7, MODE_STOP, 0, 0, 32'h0);
    check("err_pulse_max", 32'(cfg_err), 32'h1);
    check("err_no_change_max", 32'(chan_out), 32'hF);

    // Reload mid-pattern with len=0 forces the channel idle next cycle
    send(0, MODE_REPEAT, 3, 4, 32'hF);
    expect_now(0, 1'b1, 1'b0, "reload_pre");
    @(negedge clk);
    expect_now(0, 1'b1, 1'b0, "reload_pre");
    send(0, MODE_REPEAT, 3, 0, 32'hF);
    expect_now(0, 1'b0, 1'b0, "reload_len0");
    @(negedge clk);
    expect_now(0, 1'b0, 1'b0, "reload_len0");

    // Reset in the middle of a ONESHOT: no done pulse, back to reset values
    send(1, MODE_ONESHOT, 1, 2, 32'h3);
    expect_now(1, 1'b1, 1'b0, "rst_mid_run");
    @(negedge clk);
    expect_now(1, 1'b1, 1'b0, "rst_mid_run");
    @(negedge clk);
    expect_now(1, 1'b1, 1'b0, "rst_mid_run");
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_chan_out", 32'(chan_out), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    check("rst_mid_ready", 32'(bus.cfg_ready), 32'h0);
    @(negedge clk);
    check("rst_mid_done2", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_done3", 32'(done), 32'h0);
    check("rst_mid_ready1", 32'(bus.cfg_ready), 32'h0);
    @(negedge clk);
    check("rst_mid_ready2", 32'(bus.cfg_ready), 32'h1);
    check("rst_mid_chan_out2", 32'(chan_out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
